// File: rtl/core_mem_model_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_model_pkg
// Description : Shared FSM state encoding and sizing helpers for core_mem_model
// Revision    : 1.0 - initial release
// ============================================================================
package core_mem_model_pkg;

    localparam int c_STALL_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_GRANT = 2'd2
    } mem_state_t;

    // Index width that never collapses to zero for a single-word memory
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_mem_model_ram.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_model_ram
// Description : Word array with byte-strobe synchronous write, async read
// Revision    : 1.0 - initial release
// ============================================================================
module core_mem_model_ram #(
    parameter int DATA_W = 64,
    parameter int STRB_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [STRB_W-1:0] i_wr_strb,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int c_LANE_W = DATA_W / STRB_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_bit_mask;

    generate
        for (genvar g = 0; g < STRB_W; g++) begin : g_lane_mask
            assign w_bit_mask[g*c_LANE_W +: c_LANE_W] = {c_LANE_W{i_wr_strb[g]}};
        end
    endgenerate

    // Contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= (r_mem[i_wr_idx] & ~w_bit_mask) | (i_wr_data & w_bit_mask);
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/core_mem_model.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_model
// Description : Core-side memory model with programmable stall and req/gnt
// Revision    : 1.0 - initial release
// ============================================================================
module core_mem_model
    import core_mem_model_pkg::*;
#(
    parameter int                    MEM_ADDR_W  = 64,
    parameter int                    MEM_DATA_W  = 64,
    parameter int                    MEM_STRB_W  = 8,
    parameter int                    DEPTH_WORDS = 256,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic [3:0]            stall_cycles,
    input  logic                  mem_req,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_wen,
    input  logic [MEM_STRB_W-1:0] mem_strb,
    input  logic [MEM_DATA_W-1:0] mem_wdata,
    output logic                  mem_gnt,
    output logic                  mem_err,
    output logic [MEM_DATA_W-1:0] mem_rdata,
    output logic                  busy,
    output logic                  proto_err
);

    localparam int                    c_OFF_SH = $clog2(MEM_STRB_W);
    localparam int                    c_IDX_W  = clog2_min1(DEPTH_WORDS);
    localparam logic [MEM_ADDR_W-1:0] c_DEPTH  = MEM_ADDR_W'(DEPTH_WORDS);

    mem_state_t               r_state;
    mem_state_t               w_state_nxt;
    logic [c_STALL_CNT_W-1:0] r_cnt;
    logic [c_STALL_CNT_W-1:0] w_cnt_nxt;
    logic                     w_accept;

    logic [MEM_ADDR_W-1:0]    r_addr;
    logic                     r_wen;
    logic [MEM_STRB_W-1:0]    r_strb;
    logic [MEM_DATA_W-1:0]    r_wdata;
    logic                     r_proto_err;

    logic [MEM_ADDR_W-1:0]    w_off;
    logic [MEM_ADDR_W-1:0]    w_word;
    logic                     w_in_range;
    logic [c_IDX_W-1:0]       w_idx;
    logic [MEM_DATA_W-1:0]    w_ram_rdata;
    logic                     w_wr_en;
    logic                     w_attr_diff;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A stall of N holds STALL for N edges; the edge seeing cnt==1 enters GRANT
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_req) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = c_STALL_CNT_W'(stall_cycles);
                    w_state_nxt = (stall_cycles != 4'd0) ? ST_STALL : ST_GRANT;
                end
            end
            ST_STALL: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == c_STALL_CNT_W'(1)) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_strb  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= mem_addr;
            r_wen   <= mem_wen;
            r_strb  <= mem_strb;
            r_wdata <= mem_wdata;
        end
    end

    assign w_attr_diff = (mem_addr != r_addr) || (mem_wen != r_wen) ||
                         (mem_strb != r_strb) || (mem_wdata != r_wdata);

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_proto_err <= 1'b0;
        end else if ((r_state == ST_STALL) && (!mem_req || w_attr_diff)) begin
            r_proto_err <= 1'b1;
        end
    end

    // Addresses below the base wrap in the subtraction, so check them explicitly
    assign w_off      = r_addr - BASE_ADDR;
    assign w_word     = w_off >> c_OFF_SH;
    assign w_in_range = (r_addr >= BASE_ADDR) && (w_word < c_DEPTH);
    assign w_idx      = w_word[c_IDX_W-1:0];

    assign mem_gnt   = (r_state == ST_GRANT);
    assign mem_err   = mem_gnt && !w_in_range;
    assign mem_rdata = (mem_gnt && w_in_range && !r_wen) ? w_ram_rdata : '0;
    assign busy      = (r_state != ST_IDLE);
    assign proto_err = r_proto_err;

    // Reset landing on the GRANT edge must still suppress the write
    assign w_wr_en = mem_gnt && w_in_range && r_wen && g_resetn;

    core_mem_model_ram #(
        .DATA_W (MEM_DATA_W),
        .STRB_W (MEM_STRB_W),
        .DEPTH  (DEPTH_WORDS),
        .IDX_W  (c_IDX_W)
    ) u_ram (
        .clk       (g_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_idx),
        .i_wr_strb (r_strb),
        .i_wr_data (r_wdata),
        .i_rd_idx  (w_idx),
        .o_rd_data (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: doc/core_mem_model.md
CORE_MEM_MODEL -- requirements
Module: core_mem_model

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- MEM_ADDR_W, 64, request address width.
- MEM_DATA_W, 64, data width.
- MEM_STRB_W, 8, write strobe width (one bit per byte lane).
- DEPTH_WORDS, 256, number of MEM_DATA_W-bit words held.
- BASE_ADDR, 'h0, byte address of word 0.
REQ-002 Ports, one per line (name, direction, width, meaning):
- g_clk, in, 1, global clock.
- g_resetn, in, 1, global reset.
- stall_cycles, in, 4, extra wait cycles applied to the next accepted request.
- mem_req, in, 1, request valid from the core port.
- mem_addr, in, MEM_ADDR_W, request byte address.
- mem_wen, in, 1, write enable.
- mem_strb, in, MEM_STRB_W, write byte strobes.
- mem_wdata, in, MEM_DATA_W, write data.
- mem_gnt, out, 1, response valid / request complete.
- mem_err, out, 1, response error.
- mem_rdata, out, MEM_DATA_W, read data.
- busy, out, 1, transaction in progress.
- proto_err, out, 1, sticky protocol-violation flag.
REQ-003 One clock, g_clk; reset g_resetn is synchronous and active-low.

Function
REQ-004 Protocol: the requester holds mem_req and all request attributes stable until it sees mem_gnt=1; the transaction completes in the mem_gnt cycle.
REQ-005 FSM states: IDLE, STALL, GRANT.
REQ-006 IDLE with mem_req=1: latch addr/wen/strb/wdata; load the counter with stall_cycles; go to STALL if stall_cycles>0, else to GRANT.
REQ-007 STALL: decrement the counter each cycle; go to GRANT in the cycle the counter reaches 1.
REQ-008 GRANT: mem_gnt=1 for exactly one cycle, then return to IDLE; latency from the req-sample edge to mem_gnt is 1+stall_cycles cycles.
REQ-009 IDLE does not sample mem_req in the GRANT cycle; minimum issue interval is 2 cycles.
REQ-010 Word index = (addr - BASE_ADDR) >> log2(MEM_STRB_W); the low address bits are ignored.
REQ-011 Out-of-range address (addr < BASE_ADDR or index >= DEPTH_WORDS): mem_err=1 with mem_gnt, no write, mem_rdata=0.
REQ-012 In-range read: mem_rdata = the stored word during GRANT; mem_err=0.
REQ-013 In-range write: bytes with strb[i]=1 are updated at the end of the GRANT cycle; mem_rdata=0; strb=0 completes with no change.
REQ-014 mem_rdata=0 and mem_err=0 whenever mem_gnt=0.
REQ-015 busy=1 in STALL and GRANT.
REQ-016 mem_req falling, or any latched attribute changing, while in STALL sets proto_err; the transaction still completes with the latched values.
REQ-017 stall_cycles changes after acceptance do not affect the current transaction.

Reset
REQ-018 When g_resetn=0 at an edge: FSM goes to IDLE, counter=0, mem_gnt=0, mem_err=0, mem_rdata=0, busy=0, proto_err=0.
REQ-019 Reset asserted mid-transaction aborts it: no write, no mem_gnt. Memory contents are not reset.

Structure
REQ-020 The FSM state enum and the stall-counter width constant are defined in the shared package core_mem_model_pkg.
REQ-021 Sub-module core_mem_model_ram holds the word array with byte-strobe write and a combinational read port.

Verification
REQ-022 stall_cycles=0, write addr=BASE+8, strb=8'hFF, wdata=64'h1122334455667788 -> mem_gnt 1 cycle after sampling, mem_err=0.
REQ-023 Then read addr=BASE+8 with stall_cycles=3 -> mem_gnt 4 cycles after sampling, mem_rdata=64'h1122334455667788.
REQ-024 Write strb=8'h0F, wdata=64'hAAAAAAAABBBBBBBB to that word, then read -> 64'h11223344BBBBBBBB.
REQ-025 Read addr=BASE+DEPTH_WORDS*8 -> mem_gnt with mem_err=1 and mem_rdata=0; memory unchanged.
REQ-026 Drop mem_req during a 5-cycle stall -> proto_err=1 and remains set until reset.
REQ-027 Assert g_resetn=0 during STALL of a write -> no mem_gnt, the target word keeps its old value, all outputs 0.
